// File: rtl/cordic_sched_if.sv
// cordic_sched_if: bundles the requester, engine and response signals of the
// shared CORDIC scheduler. The scheduler takes the slave modport and its
// environment takes the master modport.
// Optional feature: CORDIC_SCHED_WDOG_EN adds the o_err watchdog flag.
interface cordic_sched_if #(
  parameter int DW = 18
);
  logic          i_req0_valid;
  logic          i_req1_valid;
  logic          i_req0_mode;
  logic          i_req1_mode;
  logic [DW-1:0] i_req0_a;
  logic [DW-1:0] i_req0_b;
  logic [DW-1:0] i_req1_a;
  logic [DW-1:0] i_req1_b;
  logic          o_req0_ready;
  logic          o_req1_ready;
  logic          o_cor_valid;
  logic          o_cor_mode;
  logic [DW-1:0] o_cor_i1;
  logic [DW-1:0] o_cor_i2;
  logic          i_cor_valid;
  logic [DW-1:0] i_cor_out;
  logic          o_rsp0_valid;
  logic [DW-1:0] o_rsp0_data;
  logic          o_rsp1_valid;
  logic [DW-1:0] o_rsp1_data;
  logic          o_busy;
`ifdef CORDIC_SCHED_WDOG_EN
  logic          o_err;
`endif

  modport slave (
    input  i_req0_valid, i_req1_valid, i_req0_mode, i_req1_mode,
    input  i_req0_a, i_req0_b, i_req1_a, i_req1_b,
    output o_req0_ready, o_req1_ready,
    output o_cor_valid, o_cor_mode, o_cor_i1, o_cor_i2,
    input  i_cor_valid, i_cor_out,
    output o_rsp0_valid, o_rsp0_data, o_rsp1_valid, o_rsp1_data,
    output o_busy
`ifdef CORDIC_SCHED_WDOG_EN
    , output o_err
`endif
  );

  modport master (
    output i_req0_valid, i_req1_valid, i_req0_mode, i_req1_mode,
    output i_req0_a, i_req0_b, i_req1_a, i_req1_b,
    input  o_req0_ready, o_req1_ready,
    input  o_cor_valid, o_cor_mode, o_cor_i1, o_cor_i2,
    output i_cor_valid, i_cor_out,
    input  o_rsp0_valid, o_rsp0_data, o_rsp1_valid, o_rsp1_data,
    input  o_busy
`ifdef CORDIC_SCHED_WDOG_EN
    , input o_err
`endif
  );
endinterface

// File: rtl/cordic_sched.sv
// cordic_sched: round-robin arbiter that shares one CORDIC engine (divide or
// square root) between two requesters. Accepts one operation at a time,
// launches it to the engine, waits for completion and returns the result to
// the owning requester.
// Optional feature: define CORDIC_SCHED_WDOG_EN to add a BUSY watchdog that
// gives up after TMO cycles, returns data 0 and pulses o_err.
//
// state | meaning
// IDLE  | waiting for a requester handshake; ready driven here only
// ISSUE | one-cycle launch of the latched operation to the engine
// BUSY  | waiting for the engine completion pulse
// RESP  | one-cycle response pulse to the owning requester
module cordic_sched #(
  parameter int DW  = 18,
  parameter int TMO = 31
) (
  input logic           i_clk,
  input logic           i_rst,
  cordic_sched_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          p_q, p_d;
  logic          owner_q, owner_d;
  logic          mode_q, mode_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] rsp0_data_q, rsp0_data_d;
  logic [DW-1:0] rsp1_data_q, rsp1_data_d;
  logic          rdy0, rdy1;

`ifdef CORDIC_SCHED_WDOG_EN
  localparam int         CW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(TMO - 1);
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  // Round-robin grant: p breaks ties, a lone valid requester always wins.
  always_comb begin
    rdy0 = (state_q == S_IDLE) && bus.i_req0_valid && (!bus.i_req1_valid || !p_q);
    rdy1 = (state_q == S_IDLE) && bus.i_req1_valid && (!bus.i_req0_valid ||  p_q);
  end

  // Next-state, operand latch, result capture and optional watchdog.
  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    owner_d     = owner_q;
    mode_d      = mode_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp0_data_d = rsp0_data_q;
    rsp1_data_d = rsp1_data_q;
`ifdef CORDIC_SCHED_WDOG_EN
    err_d       = err_q;
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (rdy0 || rdy1) begin
          state_d = S_ISSUE;
          owner_d = rdy1;
          p_d     = rdy0;
          mode_d  = rdy1 ? bus.i_req1_mode : bus.i_req0_mode;
          a_d     = rdy1 ? bus.i_req1_a    : bus.i_req0_a;
          b_d     = rdy1 ? bus.i_req1_b    : bus.i_req0_b;
        end
      end
      S_ISSUE: begin
        state_d = S_BUSY;
`ifdef CORDIC_SCHED_WDOG_EN
        cnt_d   = '0;
`endif
      end
      S_BUSY: begin
        if (bus.i_cor_valid) begin
          state_d = S_RESP;
          if (owner_q) rsp1_data_d = bus.i_cor_out;
          else         rsp0_data_d = bus.i_cor_out;
        end
`ifdef CORDIC_SCHED_WDOG_EN
        else if (cnt_q == CNT_TC) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          if (owner_q) rsp1_data_d = '0;
          else         rsp0_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
`ifdef CORDIC_SCHED_WDOG_EN
        err_d   = 1'b0;
`endif
      end
    endcase
  end

  // State registers; reset drops any in-flight operation.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      p_q         <= 1'b0;
      owner_q     <= 1'b0;
      mode_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      rsp0_data_q <= '0;
      rsp1_data_q <= '0;
`ifdef CORDIC_SCHED_WDOG_EN
      err_q       <= 1'b0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      owner_q     <= owner_d;
      mode_q      <= mode_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp0_data_q <= rsp0_data_d;
      rsp1_data_q <= rsp1_data_d;
`ifdef CORDIC_SCHED_WDOG_EN
      err_q       <= err_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Outputs decode directly from state so pulses are exactly one cycle.
  always_comb begin
    bus.o_req0_ready = rdy0;
    bus.o_req1_ready = rdy1;
    bus.o_busy       = (state_q != S_IDLE);
    bus.o_cor_valid  = (state_q == S_ISSUE);
    bus.o_cor_mode   = mode_q;
    bus.o_cor_i1     = a_q;
    bus.o_cor_i2     = mode_q ? '0 : b_q;
    bus.o_rsp0_valid = (state_q == S_RESP) && !owner_q;
    bus.o_rsp1_valid = (state_q == S_RESP) &&  owner_q;
    bus.o_rsp0_data  = rsp0_data_q;
    bus.o_rsp1_data  = rsp1_data_q;
`ifdef CORDIC_SCHED_WDOG_EN
    bus.o_err        = (state_q == S_RESP) && err_q;
`endif
  end

endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched: directed and randomized checks of cordic_sched against an
// operation-level reference model (round-robin pointer, latched operands,
// expected response time and data), with a behavioural engine stub.
module tb_cordic_sched;
  localparam int DW = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_sched_if #(.DW(DW)) bus();

  cordic_sched #(.DW(DW), .TMO(31)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Engine stub: completion pulse stub_lat cycles after the launch cycle.
  logic          stub_v  = 1'b0;
  logic          stray_v = 1'b0;
  logic [DW-1:0] cor_out = '0;
  int            stub_lat  = 15;
  bit            stub_hang = 1'b0;
  int            stub_cnt  = 0;

  assign bus.i_cor_valid = stub_v | stray_v;
  assign bus.i_cor_out   = cor_out;

  always @(negedge clk) begin
    if (rst) begin
      stub_v   <= 1'b0;
      stub_cnt <= 0;
    end else begin
      stub_v <= (stub_cnt == 1);
      if (bus.o_cor_valid && !stub_hang) stub_cnt <= stub_lat;
      else if (stub_cnt > 0)             stub_cnt <= stub_cnt - 1;
    end
  end

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Reference model state.
  bit            p_m = 1'b0;
  logic [DW-1:0] last_data [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input bit v0, input bit v1, input bit m0, input bit m1,
                       input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                       input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                       input int lat, input logic [DW-1:0] out, input bit hang);
    int            eg;
    int            got;
    int            extra;
    bit            em;
    logic [DW-1:0] ea, eb, ed;
    @(negedge clk);
    bus.i_req0_valid = v0; bus.i_req1_valid = v1;
    bus.i_req0_mode  = m0; bus.i_req1_mode  = m1;
    bus.i_req0_a = a0; bus.i_req0_b = b0; bus.i_req1_a = a1; bus.i_req1_b = b1;
    stub_lat = lat; stub_hang = hang; cor_out = out;
    #1;
    eg = (v0 && v1) ? int'(p_m) : (v1 ? 1 : 0);
    chk("ready_excl", 32'(bus.o_req0_ready & bus.o_req1_ready), 32'd0);
    chk("grant", bus.o_req1_ready ? 32'd1 : (bus.o_req0_ready ? 32'd0 : 32'd2), 32'(eg));
    em = (eg == 1) ? m1 : m0;
    ea = (eg == 1) ? a1 : a0;
    eb = em ? '0 : ((eg == 1) ? b1 : b0);
    @(posedge clk);
    #1;
    p_m = (eg == 0);
    // Requesters drop valid and scribble their operands after the handshake.
    bus.i_req0_valid = 1'b0; bus.i_req1_valid = 1'b0;
    bus.i_req0_a = 18'h3FFFF; bus.i_req1_a = 18'h3FFFF;
    bus.i_req0_b = DW'($urandom); bus.i_req1_b = DW'($urandom);
    bus.i_req0_mode = ~m0; bus.i_req1_mode = ~m1;
    @(negedge clk);
    chk("cor_valid", 32'(bus.o_cor_valid), 32'd1);
    chk("cor_mode", 32'(bus.o_cor_mode), 32'(em));
    chk("cor_i1", 32'(bus.o_cor_i1), 32'(ea));
    chk("cor_i2", 32'(bus.o_cor_i2), 32'(eb));
    chk("busy_issue", 32'(bus.o_busy), 32'd1);
    got = 0; extra = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (bus.o_cor_valid) extra++;
      if (bus.o_rsp0_valid || bus.o_rsp1_valid) begin
        got = i;
        break;
      end
    end
    ed = hang ? '0 : out;
    chk("rsp_latency", 32'(got), hang ? 32'd32 : 32'(lat + 1));
    chk("cor_extra", 32'(extra), 32'd0);
    chk("rsp_owner", 32'({bus.o_rsp1_valid, bus.o_rsp0_valid}), (eg == 1) ? 32'd2 : 32'd1);
    chk("rsp_data", (eg == 1) ? 32'(bus.o_rsp1_data) : 32'(bus.o_rsp0_data), 32'(ed));
    chk("other_data", (eg == 1) ? 32'(bus.o_rsp0_data) : 32'(bus.o_rsp1_data),
        32'(last_data[1-eg]));
`ifdef CORDIC_SCHED_WDOG_EN
    chk("err_pulse", 32'(bus.o_err), 32'(hang));
`endif
    last_data[eg] = ed;
    @(negedge clk);
    chk("rsp_done", 32'({bus.o_rsp1_valid, bus.o_rsp0_valid}), 32'd0);
    chk("busy_after", 32'(bus.o_busy), 32'd0);
    chk("data_hold", (eg == 1) ? 32'(bus.o_rsp1_data) : 32'(bus.o_rsp0_data), 32'(ed));
`ifdef CORDIC_SCHED_WDOG_EN
    chk("err_after", 32'(bus.o_err), 32'd0);
`endif
  endtask

  initial begin
    int            hs_cnt;
    int            both_rdy;
    int            last_hs;
    int            rsp_seen;
    int            grants [4];
    int            gaps [4];
    int            r;
    logic [DW-1:0] ra0, rb0, ra1, rb1, rout;

    last_data[0] = '0;
    last_data[1] = '0;
    bus.i_req0_valid = 1'b0; bus.i_req1_valid = 1'b0;
    bus.i_req0_mode  = 1'b0; bus.i_req1_mode  = 1'b0;
    bus.i_req0_a = '0; bus.i_req0_b = '0; bus.i_req1_a = '0; bus.i_req1_b = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_cor_valid", 32'(bus.o_cor_valid), 32'd0);
    chk("rst_rsp_valid", 32'({bus.o_rsp1_valid, bus.o_rsp0_valid}), 32'd0);
    chk("rst_rsp0_data", 32'(bus.o_rsp0_data), 32'd0);
    chk("rst_rsp1_data", 32'(bus.o_rsp1_data), 32'd0);
    chk("rst_cor_i1", 32'(bus.o_cor_i1), 32'd0);
`ifdef CORDIC_SCHED_WDOG_EN
    chk("rst_err", 32'(bus.o_err), 32'd0);
`endif
    rst = 1'b0;

    // Contention: both held valid from reset, grants alternate 0,1,0,1.
    @(negedge clk);
    stub_lat = 15; stub_hang = 1'b0; cor_out = 18'h1ABCD;
    bus.i_req0_valid = 1'b1; bus.i_req1_valid = 1'b1;
    bus.i_req0_a = 18'h00123; bus.i_req1_a = 18'h00456;
    hs_cnt = 0; both_rdy = 0; last_hs = 0;
    for (int c = 0; c < 200 && hs_cnt < 4; c++) begin
      #1;
      if (bus.o_req0_ready && bus.o_req1_ready) both_rdy++;
      if (bus.o_req0_ready || bus.o_req1_ready) begin
        grants[hs_cnt] = bus.o_req1_ready ? 1 : 0;
        gaps[hs_cnt]   = c - last_hs;
        last_hs        = c;
        hs_cnt++;
      end
      if (hs_cnt < 4) @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.i_req0_valid = 1'b0; bus.i_req1_valid = 1'b0;
    chk("cont_count", 32'(hs_cnt), 32'd4);
    chk("cont_both_ready", 32'(both_rdy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("cont_grant", 32'(grants[i]), 32'(i % 2));
      if (i > 0) chk("cont_gap", 32'(gaps[i]), 32'd18);
    end
    for (int i = 0; i < 60 && bus.o_busy; i++) @(negedge clk);
    @(negedge clk);
    chk("cont_idle", 32'(bus.o_busy), 32'd0);
    last_data[0] = 18'h1ABCD;
    last_data[1] = 18'h1ABCD;
    p_m = 1'b0;

    // Single divide on requester 0 with post-handshake operand scribble.
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 18'h08000, 18'h04000, 18'h0, 18'h0, 15, 18'h1ABCD, 1'b0);

    // Stray engine completion while idle.
    @(negedge clk);
    cor_out = 18'h2AAAA;
    stray_v = 1'b1;
    @(negedge clk);
    stray_v = 1'b0;
    rsp_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.o_rsp0_valid || bus.o_rsp1_valid || bus.o_busy) rsp_seen++;
      @(negedge clk);
    end
    chk("stray_ignored", 32'(rsp_seen), 32'd0);
    chk("stray_data0", 32'(bus.o_rsp0_data), 32'(last_data[0]));

    // Randomized operations.
    for (int n = 0; n < 20; n++) begin
      r    = int'($urandom_range(1, 3));
      ra0  = DW'($urandom); rb0 = DW'($urandom);
      ra1  = DW'($urandom); rb1 = DW'($urandom);
      rout = DW'($urandom);
      do_op(r[0], r[1], 1'($urandom), 1'($urandom), ra0, rb0, ra1, rb1,
            int'($urandom_range(1, 25)), rout, 1'b0);
    end

    // Make requester 1 preferred, then reset mid-BUSY.
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 18'h00111, 18'h00222, 18'h0, 18'h0, 3, 18'h00333, 1'b0);
    @(negedge clk);
    stub_lat = 15;
    bus.i_req0_valid = 1'b1;
    bus.i_req0_a = 18'h05555;
    @(posedge clk);
    #1;
    bus.i_req0_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(bus.o_busy), 32'd0);
    chk("mid_rst_rsp", 32'({bus.o_rsp1_valid, bus.o_rsp0_valid}), 32'd0);
    chk("mid_rst_data", 32'(bus.o_rsp0_data), 32'd0);
    chk("mid_rst_cor_i1", 32'(bus.o_cor_i1), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    p_m = 1'b0;
    last_data[0] = '0;
    last_data[1] = '0;
    rsp_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.o_rsp0_valid || bus.o_rsp1_valid || bus.o_busy) rsp_seen++;
    end
    chk("post_rst_quiet", 32'(rsp_seen), 32'd0);
    do_op(1'b1, 1'b1, 1'b1, 1'b0, 18'h04000, 18'h0, 18'h02000, 18'h01000, 15, 18'h1ABCD, 1'b0);
    do_op(1'b0, 1'b1, 1'b0, 1'b1, 18'h0, 18'h0, 18'h0C000, 18'h00077, 7, 18'h0BEEF, 1'b0);

`ifdef CORDIC_SCHED_WDOG_EN
    // Engine never completes: watchdog returns zero with o_err.
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 18'h01234, 18'h04321, 18'h0, 18'h0, 15, 18'h1ABCD, 1'b1);
`else
    // Without the watchdog a slow engine is simply waited for.
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 18'h01234, 18'h04321, 18'h0, 18'h0, 60, 18'h13579, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
